// File: rtl/audio_packer_pkg.sv
// Shared constants and types for the audio sideband packer.
// The word written to the buffer is {marker, 5-bit symbol, 10-bit RF sample}.
package audio_packer_pkg;

    localparam int SYMBOL_BITS = 5;
    localparam int MARKER_BIT  = 15;
    localparam int RF_BITS     = 10;

    // CRC-5 with polynomial x^5 + x^2 + 1, shifted MSB first
    localparam logic [SYMBOL_BITS-1:0] CRC5_POLY = 5'b00101;
    localparam logic [SYMBOL_BITS-1:0] CRC5_INIT = 5'b11111;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

endpackage

// File: rtl/crc5_calc.sv
// Combinational CRC-5 (x^5 + x^2 + 1, init all ones, MSB first, no final XOR)
// over a frame vector. Only instantiated when AUDIO_PACKER_CRC_EN is defined.
module crc5_calc
    import audio_packer_pkg::*;
#(
    parameter int WIDTH = 50
) (
    input  logic [WIDTH-1:0]       data_in,
    output logic [SYMBOL_BITS-1:0] crc_out
);

    // Bit-serial LFSR unrolled across the whole frame, most significant bit first
    always_comb begin
        logic [SYMBOL_BITS-1:0] crc_v;
        logic                   feedback;
        crc_v    = CRC5_INIT;
        feedback = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            feedback = crc_v[SYMBOL_BITS-1] ^ data_in[i];
            crc_v    = {crc_v[SYMBOL_BITS-2:0], 1'b0};
            if (feedback) begin
                crc_v = crc_v ^ CRC5_POLY;
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/audio_sideband_packer.sv
// Merges the 10-bit RF sample stream with framed PCM stereo audio carried in
// the six spare upper bits of each 16-bit buffer word.
// RF path: one-cycle registered passthrough on data_out[9:0].
// Audio path: holding register -> frame shifter -> one 5-bit symbol per cycle
// on data_out[14:10], with data_out[15] marking the first symbol of a frame.
// Optional build macro AUDIO_PACKER_CRC_EN appends a CRC-5 symbol to each frame.
module audio_sideband_packer
    import audio_packer_pkg::*;
#(
    parameter int SAMPLE_BITS = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [RF_BITS-1:0]     rf_in,
    input  logic [SAMPLE_BITS-1:0] pcm_left,
    input  logic [SAMPLE_BITS-1:0] pcm_right,
    input  logic                   pcm_ready,
    output logic [MARKER_BIT:0]    data_out,
    output logic                   busy,
    output logic                   overrun
);

    localparam int FRAME_BITS = 2 * SAMPLE_BITS + 2;
    localparam int NSYM       = (FRAME_BITS + SYMBOL_BITS - 1) / SYMBOL_BITS;
    localparam int PAD_BITS   = NSYM * SYMBOL_BITS;
`ifdef AUDIO_PACKER_CRC_EN
    localparam int CRC_SYMS   = 1;
`else
    localparam int CRC_SYMS   = 0;
`endif
    localparam int TOT_SYMS   = NSYM + CRC_SYMS;
    localparam int SHIFT_BITS = TOT_SYMS * SYMBOL_BITS;
    localparam int IDX_W      = $clog2(TOT_SYMS + 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        sym_idx_q, sym_idx_d;
    logic [SHIFT_BITS-1:0]   shift_q, shift_d;
    logic [1:0]              seq_q, seq_d;
    logic [SAMPLE_BITS-1:0]  hold_l_q, hold_l_d;
    logic [SAMPLE_BITS-1:0]  hold_r_q, hold_r_d;
    logic                    hold_valid_q, hold_valid_d;
    logic                    overrun_q, overrun_d;
    logic [MARKER_BIT:0]     data_out_q, data_out_d;

    logic [FRAME_BITS-1:0]   frame_vec;
    logic [PAD_BITS-1:0]     frame_pad;
    logic [SHIFT_BITS-1:0]   load_vec;
    logic [SYMBOL_BITS-1:0]  cur_sym;
    logic                    last_sym;
    logic                    consume;

    // Assemble {seq, left, right} and left-justify it so padding falls at the LSB end
    always_comb begin
        frame_vec = {seq_q, hold_l_q, hold_r_q};
        frame_pad = '0;
        frame_pad[PAD_BITS-1 -: FRAME_BITS] = frame_vec;
    end

`ifdef AUDIO_PACKER_CRC_EN
    logic [SYMBOL_BITS-1:0] crc_val;

    crc5_calc #(
        .WIDTH   (FRAME_BITS)
    ) u_crc5_calc (
        .data_in (frame_vec),
        .crc_out (crc_val)
    );

    assign load_vec = {frame_pad, crc_val};
`else
    assign load_vec = frame_pad;
`endif

    // Next-state logic for the symbol sequencer, holding register and output word
    always_comb begin
        state_d      = state_q;
        sym_idx_d    = sym_idx_q;
        shift_d      = shift_q;
        seq_d        = seq_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = overrun_q;

        cur_sym  = shift_q[SHIFT_BITS-1 -: SYMBOL_BITS];
        last_sym = (state_q == SEND) && (sym_idx_q == IDX_W'(TOT_SYMS - 1));
        consume  = hold_valid_q && ((state_q == IDLE) || last_sym);

        data_out_d = '0;
        data_out_d[RF_BITS-1:0] = rf_in;

        if (state_q == SEND) begin
            data_out_d[MARKER_BIT] = (sym_idx_q == '0);
            data_out_d[MARKER_BIT-1 -: SYMBOL_BITS] = cur_sym;
            shift_d   = shift_q << SYMBOL_BITS;
            sym_idx_d = sym_idx_q + 1'b1;
            if (last_sym && !hold_valid_q) begin
                state_d = IDLE;
            end
        end

        if (consume) begin
            shift_d      = load_vec;
            sym_idx_d    = '0;
            seq_d        = seq_q + 2'd1;
            state_d      = SEND;
            hold_valid_d = 1'b0;
        end

        if (pcm_ready) begin
            if (!hold_valid_q || consume) begin
                hold_l_d     = pcm_left;
                hold_r_d     = pcm_right;
                hold_valid_d = 1'b1;
            end else begin
                overrun_d    = 1'b1;
            end
        end
    end

    // Register all state; synchronous reset aborts any frame in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            sym_idx_q    <= '0;
            shift_q      <= '0;
            seq_q        <= '0;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            hold_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            sym_idx_q    <= sym_idx_d;
            shift_q      <= shift_d;
            seq_q        <= seq_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            hold_valid_q <= hold_valid_d;
            overrun_q    <= overrun_d;
            data_out_q   <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign busy     = (state_q == SEND);
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_audio_sideband_packer.sv
// Directed testbench for audio_sideband_packer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_audio_sideband_packer;

    localparam int SAMPLE_BITS = 24;
`ifdef AUDIO_PACKER_CRC_EN
    localparam int TOT = 11;
`else
    localparam int TOT = 10;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  rf_in = '0;
    logic [23:0] pcm_left = '0;
    logic [23:0] pcm_right = '0;
    logic        pcm_ready = 1'b0;
    logic [15:0] data_out;
    logic        busy;
    logic        overrun;

    int n_compared = 0;
    int n_mismatched = 0;

    // Hand-derived sideband words for L=ABCDEF, R=123456, seq=0
    logic [5:0] exp_sb [10] = '{6'h25, 6'h0B, 6'h19, 6'h17, 6'h17,
                                6'h11, 6'h04, 6'h0D, 6'h02, 6'h16};

    always #5 clock = ~clock;

    audio_sideband_packer #(
        .SAMPLE_BITS (SAMPLE_BITS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rf_in     (rf_in),
        .pcm_left  (pcm_left),
        .pcm_right (pcm_right),
        .pcm_ready (pcm_ready),
        .data_out  (data_out),
        .busy      (busy),
        .overrun   (overrun)
    );

    // Reference CRC-5, x^5+x^2+1, init 11111, MSB first
    function automatic logic [4:0] crc5_ref(input logic [49:0] bits);
        logic [4:0] c;
        logic fb;
        c = 5'b11111;
        for (int i = 49; i >= 0; i--) begin
            fb = c[4] ^ bits[i];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'b00101;
        end
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        pcm_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rf_in = 10'h155;
        repeat (2) @(negedge clock);
        n_compared++;
        if (data_out !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data_out: got %h expected %h", data_out, 16'h0000);
        end
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        n_compared++;
        if (overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_overrun: got %b expected 0", overrun);
        end
        reset = 1'b0;
    endtask

    task automatic test_rf_ramp();
        logic [15:0] exp;
        for (int i = 0; i < 1024; i++) begin
            rf_in = i[9:0];
            @(negedge clock);
            exp = {6'b0, i[9:0]};
            n_compared++;
            if (data_out !== exp) begin
                n_mismatched++;
                $display("[TB] FAIL rf_ramp[%0d]: got %h expected %h", i, data_out, exp);
            end
            n_compared++;
            if (busy !== 1'b0 || overrun !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL rf_ramp_flags[%0d]: got busy=%b overrun=%b expected 0/0", i, busy, overrun);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [5:0]  sb;
        logic [4:0]  exp_crc;
        logic        exp_busy;
        exp_crc = crc5_ref({2'b00, 24'hABCDEF, 24'h123456});
        do_reset();
        rf_in     = 10'h3FF;
        pcm_left  = 24'hABCDEF;
        pcm_right = 24'h123456;
        pcm_ready = 1'b1;
        @(negedge clock);
        pcm_ready = 1'b0;
        @(negedge clock);
        n_compared++;
        if (busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL single_busy_start: got %b expected 1", busy);
        end
        for (int j = 0; j < TOT; j++) begin
            @(negedge clock);
            if (j < 10) sb = exp_sb[j];
            else        sb = {1'b0, exp_crc};
            n_compared++;
            if (data_out !== {sb, 10'h3FF}) begin
                n_mismatched++;
                $display("[TB] FAIL single_sym[%0d]: got %h expected %h", j, data_out, {sb, 10'h3FF});
            end
            exp_busy = (j < TOT - 1);
            n_compared++;
            if (busy !== exp_busy) begin
                n_mismatched++;
                $display("[TB] FAIL single_busy[%0d]: got %b expected %b", j, busy, exp_busy);
            end
        end
        @(negedge clock);
        n_compared++;
        if (data_out !== 16'h03FF || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL single_idle_after: got %h busy=%b expected 03ff busy=0", data_out, busy);
        end
    endtask

    task automatic test_seq();
        logic [1:0] es;
        logic [5:0] exp;
        do_reset();
        rf_in     = 10'h3FF;
        pcm_left  = 24'hABCDEF;
        pcm_right = 24'h123456;
        for (int s = 0; s < 5; s++) begin
            es  = s[1:0];
            exp = {1'b1, es, 3'b101};
            pcm_ready = 1'b1;
            @(negedge clock);
            pcm_ready = 1'b0;
            repeat (2) @(negedge clock);
            n_compared++;
            if (data_out[15:10] !== exp) begin
                n_mismatched++;
                $display("[TB] FAIL seq_frame[%0d]: got %h expected %h", s, data_out[15:10], exp);
            end
            repeat (997) @(negedge clock);
        end
        n_compared++;
        if (overrun !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL seq_overrun: got %b expected 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        logic exp_mark;
        do_reset();
        rf_in     = 10'h3FF;
        pcm_left  = 24'hABCDEF;
        pcm_right = 24'h123456;
        pcm_ready = 1'b1;
        @(negedge clock);
        pcm_left  = 24'h111111;
        pcm_right = 24'h222222;
        @(negedge clock);
        n_compared++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second_accept: got overrun=%b busy=%b expected 0/1", overrun, busy);
        end
        pcm_left  = 24'h777777;
        pcm_right = 24'h777777;
        @(negedge clock);
        pcm_ready = 1'b0;
        n_compared++;
        if (overrun !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_third_dropped: got overrun=%b expected 1", overrun);
        end
        for (int j = 3; j <= 2 + 2 * TOT; j++) begin
            if (j > 3) @(negedge clock);
            exp_busy = (j <= 1 + 2 * TOT);
            exp_mark = (j == 3) || (j == 3 + TOT);
            n_compared++;
            if (busy !== exp_busy || data_out[15] !== exp_mark) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_cycle[%0d]: got busy=%b marker=%b expected %b/%b",
                         j, busy, data_out[15], exp_busy, exp_mark);
            end
            if (j == 3) begin
                n_compared++;
                if (data_out !== 16'h97FF) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_first_marker: got %h expected 97ff", data_out);
                end
            end
            if (j == 3 + TOT) begin
                n_compared++;
                if (data_out !== {6'h28, 10'h3FF}) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_second_marker: got %h expected %h", data_out, {6'h28, 10'h3FF});
                end
            end
        end
        repeat (50) @(negedge clock);
        n_compared++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_sticky: got overrun=%b busy=%b expected 1/0", overrun, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        rf_in     = 10'h3FF;
        pcm_left  = 24'hABCDEF;
        pcm_right = 24'h123456;
        pcm_ready = 1'b1;
        @(negedge clock);
        pcm_ready = 1'b0;
        repeat (6) @(negedge clock);
        n_compared++;
        if (data_out !== {6'h17, 10'h3FF}) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_sym4: got %h expected %h", data_out, {6'h17, 10'h3FF});
        end
        reset = 1'b1;
        @(negedge clock);
        n_compared++;
        if (data_out !== 16'h0000 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_abort: got %h busy=%b expected 0000 busy=0", data_out, busy);
        end
        reset = 1'b0;
        pcm_ready = 1'b1;
        @(negedge clock);
        pcm_ready = 1'b0;
        repeat (2) @(negedge clock);
        n_compared++;
        if (data_out !== 16'h97FF) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_seq0: got %h expected 97ff", data_out);
        end
        repeat (TOT + 2) @(negedge clock);
    endtask

`ifdef AUDIO_PACKER_CRC_EN
    task automatic test_crc_flip();
        logic [4:0] crc_orig;
        logic [4:0] crc_flip;
        crc_orig = crc5_ref({2'b00, 24'hABCDEF, 24'h123456});
        crc_flip = crc5_ref({2'b00, 24'hABCDEE, 24'h123456});
        do_reset();
        rf_in     = 10'h3FF;
        pcm_left  = 24'hABCDEE;
        pcm_right = 24'h123456;
        pcm_ready = 1'b1;
        @(negedge clock);
        pcm_ready = 1'b0;
        repeat (12) @(negedge clock);
        n_compared++;
        if (data_out[15:10] !== {1'b0, crc_flip}) begin
            n_mismatched++;
            $display("[TB] FAIL crc_flip_value: got %h expected %h", data_out[15:10], {1'b0, crc_flip});
        end
        n_compared++;
        if (data_out[14:10] === crc_orig) begin
            n_mismatched++;
            $display("[TB] FAIL crc_flip_changed: got %h required different from %h", data_out[14:10], crc_orig);
        end
        repeat (4) @(negedge clock);
    endtask
`endif

    initial begin
        $display("[TB] audio_sideband_packer directed test, %0d symbols per frame", TOT);
        test_reset();
        test_rf_ramp();
        test_single_frame();
        test_seq();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef AUDIO_PACKER_CRC_EN
        test_crc_flip();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
